// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter in front of a FIFO, with bounded burst hold.
// N requesters share one W-bit write port. A winner may keep the grant for up
// to MAX_BURST consecutive beats before the pointer moves on.
// Optional: define FIFO_ARB_STATS_EN to add per-requester accepted-beat counters
// on beat_count_o (16 bits each, saturating).
module fifo_write_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_valid_i,
  input  logic [N*W-1:0]       req_data_i,
  output logic [N-1:0]         req_ready_o,
  input  logic                 fifo_full_i,
  output logic                 fifo_write_en_o,
  output logic [W-1:0]         fifo_write_data_o,
  output logic [$clog2(N)-1:0] grant_id_o,
`ifdef FIFO_ARB_STATS_EN
  output logic [N*16-1:0]      beat_count_o,
`endif
  output logic                 burst_active_o
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q;
  logic [IdxW-1:0] last_ptr_q;
  logic [IdxW-1:0] owner_q;
  logic [CntW-1:0] burst_cnt_q;

  logic [IdxW-1:0] scan_idx;
  logic [IdxW-1:0] winner;
  logic            win_found;
  logic [IdxW-1:0] grant_idx;
  logic            grant_vld;
  logic            accept;

  // Rotating-priority search starting just after the last served requester.
  always_comb begin
    scan_idx  = '0;
    winner    = '0;
    win_found = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      scan_idx = IdxW'((int'(last_ptr_q) + k) % int'(N));
      if (!win_found && req_valid_i[scan_idx]) begin
        winner    = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  // Select the granted requester: the burst owner, or the round-robin winner.
  always_comb begin
    if (state_q == StBurst) begin
      grant_idx = owner_q;
      grant_vld = req_valid_i[owner_q];
    end else begin
      grant_idx = winner;
      grant_vld = win_found;
    end
  end

  // Zero-latency accept path; reset low forces every strobe off.
  always_comb begin
    req_ready_o = '0;
    if (grant_vld && !fifo_full_i && rst_ni) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  assign accept          = |req_ready_o;
  assign fifo_write_en_o = accept;

  // Write-data mux from the granted requester; zero when nobody is granted.
  always_comb begin
    fifo_write_data_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_vld && grant_idx == IdxW'(i)) begin
        fifo_write_data_o = req_data_i[i*W +: W];
      end
    end
  end

  // Arbitration FSM; a full FIFO freezes state, pointer and count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      last_ptr_q     <= IdxW'(N - 1);
      owner_q        <= '0;
      burst_cnt_q    <= '0;
      grant_id_o     <= '0;
      burst_active_o <= 1'b0;
    end else if (accept) begin
      unique case (state_q)
        StIdle: begin
          grant_id_o  <= winner;
          owner_q     <= winner;
          burst_cnt_q <= CntW'(1);
          if (MAX_BURST > 1) begin
            state_q        <= StBurst;
            burst_active_o <= 1'b1;
          end else begin
            last_ptr_q <= winner;
          end
        end
        StBurst: begin
          grant_id_o  <= owner_q;
          burst_cnt_q <= burst_cnt_q + CntW'(1);
          if (burst_cnt_q + CntW'(1) == CntW'(MAX_BURST)) begin
            last_ptr_q     <= owner_q;
            state_q        <= StIdle;
            burst_active_o <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end else if (state_q == StBurst && !req_valid_i[owner_q] && !fifo_full_i) begin
      // Owner went idle: give up the grant, costing one bubble cycle.
      last_ptr_q     <= owner_q;
      state_q        <= StIdle;
      burst_active_o <= 1'b0;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < int'(N); g++) begin : g_stats
    logic [15:0] cnt_q;
    // Per-requester accepted-beat counter, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (req_ready_o[g] && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign beat_count_o[g*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: MAX_BURST=4 main instance plus a
// MAX_BURST=1 instance sharing the same requester inputs.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        fifo_full;

  logic [3:0]  ready4, ready1;
  logic        wen4, wen1;
  logic [7:0]  wdata4, wdata1;
  logic [1:0]  gid4, gid1;
  logic        bact4, bact1;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] bc4, bc1;
`endif

  int checks   = 0;
  int failures = 0;

  fifo_write_arbiter #(.N(4), .W(8), .MAX_BURST(4)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_data_i       (req_data),
    .req_ready_o      (ready4),
    .fifo_full_i      (fifo_full),
    .fifo_write_en_o  (wen4),
    .fifo_write_data_o(wdata4),
    .grant_id_o       (gid4),
`ifdef FIFO_ARB_STATS_EN
    .beat_count_o     (bc4),
`endif
    .burst_active_o   (bact4)
  );

  fifo_write_arbiter #(.N(4), .W(8), .MAX_BURST(1)) dut1 (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_data_i       (req_data),
    .req_ready_o      (ready1),
    .fifo_full_i      (fifo_full),
    .fifo_write_en_o  (wen1),
    .fifo_write_data_o(wdata1),
    .grant_id_o       (gid1),
`ifdef FIFO_ARB_STATS_EN
    .beat_count_o     (bc1),
`endif
    .burst_active_o   (bact1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int id;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h0;
    fifo_full = 1'b0;

    // Reset state with every requester asserting valid.
    cyc();
    #1;
    chk("rst_ready", 64'(ready4), 64'h0);
    chk("rst_wen", 64'(wen4), 64'h0);
    chk("rst_gid", 64'(gid4), 64'h0);
    chk("rst_bact", 64'(bact4), 64'h0);
    chk("rst_ready1", 64'(ready1), 64'h0);
    cyc();
    rst_n = 1'b1;

    // Single requester, 8 beats back-to-back.
    req_valid = 4'b0001;
    for (int b = 0; b < 8; b++) begin
      req_data[7:0] = 8'(b);
      #1;
      chk("single_wen", 64'(wen4), 64'h1);
      chk("single_ready", 64'(ready4), 64'h1);
      chk("single_data", 64'(wdata4), 64'(b));
      chk("single_bact", 64'(bact4), 64'((b % 4) != 0));
      chk("single_data1", 64'(wdata1), 64'(b));
      cyc();
      chk("single_gid", 64'(gid4), 64'h0);
    end
    req_valid = 4'b0000;
    cyc();

    // All valid: bursts of 4 on dut, per-beat rotation on dut1.
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'hA3A2A1A0;
    for (int k = 0; k < 17; k++) begin
      id = (k / 4) % 4;
      #1;
      chk("all_ready", 64'(ready4), 64'(4'b0001 << id));
      chk("all_data", 64'(wdata4), 64'(8'hA0 + id));
      chk("rr1_ready", 64'(ready1), 64'(4'b0001 << (k % 4)));
      chk("rr1_data", 64'(wdata1), 64'(8'hA0 + (k % 4)));
      chk("rr1_bact", 64'(bact1), 64'h0);
      cyc();
      chk("all_gid", 64'(gid4), 64'(id));
      chk("rr1_gid", 64'(gid1), 64'(k % 4));
    end

    // Full for 3 cycles in req2's burst at burst_cnt=2.
    do_reset();
    req_valid = 4'b0100;
    for (int b = 0; b < 2; b++) begin
      req_data[23:16] = 8'(8'h20 + b);
      #1;
      chk("full_pre_ready", 64'(ready4), 64'h4);
      chk("full_pre_data", 64'(wdata4), 64'(8'h20 + b));
      cyc();
    end
    req_data[23:16] = 8'h22;
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("full_wen", 64'(wen4), 64'h0);
      chk("full_ready", 64'(ready4), 64'h0);
      cyc();
      chk("full_bact", 64'(bact4), 64'h1);
    end
    fifo_full = 1'b0;
    for (int b = 2; b < 4; b++) begin
      req_data[23:16] = 8'(8'h20 + b);
      #1;
      chk("full_post_ready", 64'(ready4), 64'h4);
      chk("full_post_data", 64'(wdata4), 64'(8'h20 + b));
      cyc();
    end
    chk("full_end_bact", 64'(bact4), 64'h0);
    chk("full_end_gid", 64'(gid4), 64'h2);

    // Owner req1 drops valid after 2 beats; req3 takes over after a bubble.
    do_reset();
    req_valid = 4'b1010;
    req_data  = 32'h33221100;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("drop_ready", 64'(ready4), 64'h2);
      chk("drop_data", 64'(wdata4), 64'h11);
      cyc();
    end
    req_valid = 4'b1000;
    #1;
    chk("bubble_wen", 64'(wen4), 64'h0);
    chk("bubble_bact", 64'(bact4), 64'h1);
    cyc();
    chk("bubble_idle", 64'(bact4), 64'h0);
    #1;
    chk("next_ready", 64'(ready4), 64'h8);
    chk("next_data", 64'(wdata4), 64'h33);
    cyc();
    chk("next_gid", 64'(gid4), 64'h3);
    chk("next_bact", 64'(bact4), 64'h1);

    // Asynchronous reset mid-burst, then lowest valid index wins.
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 64'(ready4), 64'h0);
    chk("mrst_wen", 64'(wen4), 64'h0);
    chk("mrst_bact", 64'(bact4), 64'h0);
    chk("mrst_gid", 64'(gid4), 64'h0);
    cyc();
    req_valid = 4'b1010;
    rst_n = 1'b1;
    #1;
    chk("mrst_first", 64'(ready4), 64'h2);
    cyc();
    chk("mrst_first_gid", 64'(gid4), 64'h1);
    req_valid = 4'b0000;
    cyc();

`ifdef FIFO_ARB_STATS_EN
    // 5 accepts by req0, then 3 by req2.
    do_reset();
    req_valid = 4'b0001;
    for (int b = 0; b < 5; b++) cyc();
    req_valid = 4'b0000;
    cyc();
    cyc();
    req_valid = 4'b0100;
    for (int b = 0; b < 3; b++) cyc();
    req_valid = 4'b0000;
    cyc();
    chk("stats_count", bc4, {16'd0, 16'd3, 16'd0, 16'd5});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
